// File: rtl/bcd_modcnt.sv
// -----------------------------------------------------------------------------
// bcd_modcnt -- two-digit BCD modulo counter, MINV..MAXV, up/down, with load
//
// The count is held as two BCD digits (tens QH, units QL) and always stays
// inside [MINV, MAXV]. Wrapping at either end raises the combinational CA in
// the same cycle, so the next stage can use CA as its EN. Stages cascaded
// this way (sharing UP) step on the same clock edge.
//
// Parameters
//   MINV : lowest count value (0..98)
//   MAXV : highest count value (MINV+1..99)
//   HW   : tens-digit width; MAXV/10 must fit in HW bits
//
// Ports
//   CLK   in   clock, all state changes on the rising edge
//   RST   in   synchronous active-high reset, count <- MINV
//   EN    in   count enable, one step per enabled edge
//   UP    in   direction, 1 = increment, 0 = decrement
//   LD    in   parallel load request (has priority over EN)
//   DH    in   load tens digit  [HW-1:0]
//   DL    in   load units digit [3:0]
//   QH    out  tens digit of the count (registered)
//   QL    out  units digit of the count (registered)
//   CA    out  carry/borrow, high while this edge will wrap (combinational)
//   LDERR out  high for one cycle after a rejected load (registered)
// -----------------------------------------------------------------------------
module bcd_modcnt #(
  parameter int MINV = 0,
  parameter int MAXV = 59,
  parameter int HW   = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          UP,
  input  logic          LD,
  input  logic [HW-1:0] DH,
  input  logic [3:0]    DL,
  output logic [HW-1:0] QH,
  output logic [3:0]    QL,
  output logic          CA,
  output logic          LDERR
);

  // Parameter sanity, checked while the design is elaborated.
  if (MINV < 0 || MINV > 98) begin : g_bad_minv
    $error("bcd_modcnt: MINV must lie in 0..98");
  end
  if (MAXV <= MINV || MAXV > 99) begin : g_bad_maxv
    $error("bcd_modcnt: MAXV must lie in MINV+1..99");
  end
  if (HW < 1 || (MAXV / 10) >= (1 << HW)) begin : g_bad_hw
    $error("bcd_modcnt: HW too narrow for the tens digit of MAXV");
  end

  // Range limits split into BCD digits, so every compare below is per digit.
  localparam logic [HW-1:0] MIN_H = HW'(MINV / 10);
  localparam logic [3:0]    MIN_L = 4'(MINV % 10);
  localparam logic [HW-1:0] MAX_H = HW'(MAXV / 10);
  localparam logic [3:0]    MAX_L = 4'(MAXV % 10);

  logic at_max;
  logic at_min;
  logic ld_ge_min;
  logic ld_le_max;
  logic ld_ok;

  assign at_max = (QH == MAX_H) && (QL == MAX_L);
  assign at_min = (QH == MIN_H) && (QL == MIN_L);

  // With the units digit limited to 0..9, ordering by (tens, units) is the
  // same as ordering by decimal value, so no binary value is ever formed.
  assign ld_ge_min = (DH > MIN_H) || ((DH == MIN_H) && (DL >= MIN_L));
  assign ld_le_max = (DH < MAX_H) || ((DH == MAX_H) && (DL <= MAX_L));
  assign ld_ok     = (DL <= 4'd9) && ld_ge_min && ld_le_max;

  assign CA = EN & ~LD & ~RST & ((UP & at_max) | (~UP & at_min));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      QH    <= MIN_H;
      QL    <= MIN_L;
      LDERR <= 1'b0;
    end else if (LD) begin
      // A load always wins over counting; a rejected load leaves the count.
      if (ld_ok) begin
        QH    <= DH;
        QL    <= DL;
        LDERR <= 1'b0;
      end else begin
        LDERR <= 1'b1;
      end
    end else begin
      LDERR <= 1'b0;
      if (EN) begin
        if (UP) begin
          if (at_max) begin
            QH <= MIN_H;
            QL <= MIN_L;
          end else if (QL == 4'd9) begin
            QH <= QH + HW'(1);
            QL <= 4'd0;
          end else begin
            QL <= QL + 4'd1;
          end
        end else begin
          if (at_min) begin
            QH <= MAX_H;
            QL <= MAX_L;
          end else if (QL == 4'd0) begin
            QH <= QH - HW'(1);
            QL <= 4'd9;
          end else begin
            QL <= QL - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_modcnt.sv
// -----------------------------------------------------------------------------
// tb_bcd_modcnt -- self-checking bench for bcd_modcnt
//
// Instances: a default 00..59 counter driven from a vector table, a 12 h
// counter (01..12), and a 60/24 cascade (minutes feeding hours through CA).
// Inputs change 1 time unit after a rising edge; CA is checked before the
// next edge, registered outputs 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_bcd_modcnt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- default instance: 00..59 ----------------
  logic       rst, ld, en, up;
  logic [2:0] dh;
  logic [3:0] dl;
  logic [2:0] qh;
  logic [3:0] ql;
  logic       ca, lderr;

  bcd_modcnt #(.MINV(0), .MAXV(59), .HW(3)) u60 (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .DH(dh), .DL(dl),
    .QH(qh), .QL(ql), .CA(ca), .LDERR(lderr)
  );

  // ---------------- 12 h instance: 01..12 ----------------
  logic       r12, ld12, en12, up12;
  logic [0:0] dh12;
  logic [3:0] dl12;
  logic [0:0] qh12;
  logic [3:0] ql12;
  logic       ca12, lderr12;

  bcd_modcnt #(.MINV(1), .MAXV(12), .HW(1)) u12 (
    .CLK(clk), .RST(r12), .EN(en12), .UP(up12), .LD(ld12), .DH(dh12), .DL(dl12),
    .QH(qh12), .QL(ql12), .CA(ca12), .LDERR(lderr12)
  );

  // ---------------- cascade: minutes (00..59) -> hours (00..23) ----------------
  logic       c_rst, c_ld, c_en, c_up;
  logic [2:0] m_dh, m_qh;
  logic [3:0] m_dl, m_ql, h_dl, h_ql;
  logic [1:0] h_dh, h_qh;
  logic       m_ca, h_ca, m_lderr, h_lderr;

  bcd_modcnt #(.MINV(0), .MAXV(59), .HW(3)) u_min (
    .CLK(clk), .RST(c_rst), .EN(c_en), .UP(c_up), .LD(c_ld), .DH(m_dh), .DL(m_dl),
    .QH(m_qh), .QL(m_ql), .CA(m_ca), .LDERR(m_lderr)
  );

  bcd_modcnt #(.MINV(0), .MAXV(23), .HW(2)) u_hour (
    .CLK(clk), .RST(c_rst), .EN(m_ca), .UP(c_up), .LD(c_ld), .DH(h_dh), .DL(h_dl),
    .QH(h_qh), .QL(h_ql), .CA(h_ca), .LDERR(h_lderr)
  );

  // One table row: inputs for one edge, CA expected before that edge,
  // count and LDERR expected after it.
  typedef struct {
    int rst, ld, en, up, dh, dl;
    int exp_ca, exp_qh, exp_ql, exp_lderr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b1; dh = '0; dl = '0;
    r12 = 1'b1; ld12 = 1'b0; en12 = 1'b0; up12 = 1'b1; dh12 = '0; dl12 = '0;
    c_rst = 1'b1; c_ld = 1'b0; c_en = 1'b0; c_up = 1'b1;
    m_dh = '0; m_dl = '0; h_dh = '0; h_dl = '0;

    //               rst ld en up dh dl   ca qh ql lderr
    vecs.push_back('{1, 0, 0, 1, 0, 0,   0, 0, 0, 0});  // reset cycle 1
    vecs.push_back('{1, 0, 1, 1, 0, 0,   0, 0, 0, 0});  // reset cycle 2, CA masked
    vecs.push_back('{0, 0, 0, 1, 0, 0,   0, 0, 0, 0});  // released, hold 00
    vecs.push_back('{0, 1, 1, 1, 4, 2,   0, 4, 2, 0});  // load 42, EN ignored
    vecs.push_back('{0, 1, 0, 1, 0, 12,  0, 4, 2, 1});  // DL=12 rejected
    vecs.push_back('{0, 0, 0, 1, 0, 0,   0, 4, 2, 0});  // LDERR lasts one cycle
    vecs.push_back('{0, 1, 0, 1, 7, 5,   0, 4, 2, 1});  // 75 > 59 rejected
    vecs.push_back('{0, 1, 0, 1, 5, 9,   0, 5, 9, 0});  // back-to-back valid load
    vecs.push_back('{0, 0, 1, 1, 0, 0,   1, 0, 0, 0});  // 59 up -> 00 with CA
    vecs.push_back('{0, 0, 1, 0, 0, 0,   1, 5, 9, 0});  // 00 down -> 59 with CA
    vecs.push_back('{0, 0, 1, 0, 0, 0,   0, 5, 8, 0});  // 59 -> 58
    vecs.push_back('{0, 1, 0, 0, 1, 0,   0, 1, 0, 0});  // load 10
    vecs.push_back('{0, 0, 1, 0, 0, 0,   0, 0, 9, 0});  // 10 down -> 09
    vecs.push_back('{0, 0, 1, 1, 0, 0,   0, 1, 0, 0});  // 09 up -> 10
    vecs.push_back('{0, 1, 0, 1, 5, 9,   0, 5, 9, 0});  // load 59
    vecs.push_back('{0, 1, 1, 1, 3, 3,   0, 3, 3, 0});  // LD masks CA at 59
    vecs.push_back('{0, 1, 1, 1, 6, 0,   0, 3, 3, 1});  // 60 rejected, EN ignored
    vecs.push_back('{0, 0, 0, 0, 0, 0,   0, 3, 3, 0});  // idle hold
    vecs.push_back('{1, 1, 1, 1, 4, 2,   0, 0, 0, 0});  // RST beats LD and EN
    vecs.push_back('{0, 1, 0, 1, 0, 0,   0, 0, 0, 0});  // load 00 is valid

    #1;
    foreach (vecs[i]) begin
      rst = 1'(vecs[i].rst); ld = 1'(vecs[i].ld);
      en  = 1'(vecs[i].en);  up = 1'(vecs[i].up);
      dh  = 3'(vecs[i].dh);  dl = 4'(vecs[i].dl);
      #1;
      check($sformatf("vec%0d ca", i), int'(ca), vecs[i].exp_ca);
      step();
      check($sformatf("vec%0d qh", i), int'(qh), vecs[i].exp_qh);
      check($sformatf("vec%0d ql", i), int'(ql), vecs[i].exp_ql);
      check($sformatf("vec%0d lderr", i), int'(lderr), vecs[i].exp_lderr);
    end

    // Full up count from 00: 00..59 then 00, CA only while at 59.
    ld = 1'b0; rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int v = 0; v < 60; v++) begin
      #1;
      check($sformatf("up%0d ca", v), int'(ca), (v == 59) ? 1 : 0);
      step();
      check($sformatf("up%0d qh", v), int'(qh), ((v + 1) % 60) / 10);
      check($sformatf("up%0d ql", v), int'(ql), ((v + 1) % 60) % 10);
    end
    en = 1'b0;

    // 12 h instance.
    step();
    check("h12 reset qh", int'(qh12), 0);
    check("h12 reset ql", int'(ql12), 1);
    r12 = 1'b0; ld12 = 1'b1; dh12 = 1'b1; dl12 = 4'd2;
    step();
    check("h12 load12 ql", int'(ql12), 2);
    ld12 = 1'b0; en12 = 1'b1; up12 = 1'b1;
    #1;
    check("h12 up ca", int'(ca12), 1);
    step();
    check("h12 12->01 qh", int'(qh12), 0);
    check("h12 12->01 ql", int'(ql12), 1);
    up12 = 1'b0;
    #1;
    check("h12 down ca", int'(ca12), 1);
    step();
    check("h12 01->12 qh", int'(qh12), 1);
    check("h12 01->12 ql", int'(ql12), 2);
    en12 = 1'b0; ld12 = 1'b1; dh12 = 1'b0; dl12 = 4'd0;
    step();
    check("h12 load00 lderr", int'(lderr12), 1);
    check("h12 load00 ql", int'(ql12), 2);
    dh12 = 1'b1; dl12 = 4'd3;
    step();
    check("h12 load13 lderr", int'(lderr12), 1);
    check("h12 load13 qh", int'(qh12), 1);
    ld12 = 1'b0;
    step();
    check("h12 lderr clear", int'(lderr12), 0);

    // Cascade: 23:59 up -> 00:00 on one edge.
    c_rst = 1'b0; c_ld = 1'b1;
    m_dh = 3'd5; m_dl = 4'd9; h_dh = 2'd2; h_dl = 4'd3;
    step();
    check("casc load hour", int'(h_qh) * 10 + int'(h_ql), 23);
    check("casc load min", int'(m_qh) * 10 + int'(m_ql), 59);
    c_ld = 1'b0; c_en = 1'b1; c_up = 1'b1;
    #1;
    check("casc up min ca", int'(m_ca), 1);
    check("casc up hour ca", int'(h_ca), 1);
    step();
    check("casc up hour", int'(h_qh) * 10 + int'(h_ql), 0);
    check("casc up min", int'(m_qh) * 10 + int'(m_ql), 0);
    // Down across the same boundary: 00:00 -> 23:59.
    c_up = 1'b0;
    #1;
    check("casc down min ca", int'(m_ca), 1);
    check("casc down hour ca", int'(h_ca), 1);
    step();
    check("casc down hour", int'(h_qh) * 10 + int'(h_ql), 23);
    check("casc down min", int'(m_qh) * 10 + int'(m_ql), 59);
    // Next step down touches only the minutes.
    #1;
    check("casc 58 hour ca", int'(h_ca), 0);
    step();
    check("casc 58 hour", int'(h_qh) * 10 + int'(h_ql), 23);
    check("casc 58 min", int'(m_qh) * 10 + int'(m_ql), 58);
    c_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
